// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network layer controllers.
// Holds the sequencer state encoding and the default layer geometry.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } fc_seq_state_t;

    localparam int N_IN_MAX_DEF  = 10;
    localparam int N_OUT_MAX_DEF = 2;
    localparam int W_STRIDE      = N_IN_MAX_DEF + 1;

    // Each neuron owns N_IN_MAX data weights plus one bias slot.
    function automatic int fc_w_stride(input int n_in_max);
        return n_in_max + 1;
    endfunction

endpackage

// File: rtl/fc_seq_valid_pipe.sv
// Read-latency delay line carrying issue-valid and bias flags to the MAC.
// A flush empties every stage so no in-flight term reaches the MAC.
module fc_seq_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic vld_i,
    input  logic bias_i,
    output logic vld_o,
    output logic bias_o
);

    logic [DEPTH-1:0] vld_pipe_q;
    logic [DEPTH-1:0] bias_pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            bias_pipe_q <= '0;
        end else if (flush_i) begin
            vld_pipe_q  <= '0;
            bias_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]  <= vld_i;
            bias_pipe_q[0] <= bias_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                bias_pipe_q[i] <= bias_pipe_q[i-1];
            end
        end
    end

    assign vld_o  = vld_pipe_q[DEPTH-1];
    assign bias_o = bias_pipe_q[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: walks neurons and terms, drives MAC control.
// Optional FC_SEQ_PERF_CNT_EN adds a saturating stall_cnt output.
module fc_layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN_MAX  = N_IN_MAX_DEF,
    parameter int N_OUT_MAX = N_OUT_MAX_DEF,
    parameter int RD_LAT    = 1,
    parameter int IDX_W     = $clog2(N_IN_MAX + 1),
    parameter int OUT_W     = (N_OUT_MAX > 1) ? $clog2(N_OUT_MAX) : 1,
    parameter int W_ADDR_W  = $clog2(N_OUT_MAX * (N_IN_MAX + 1))
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [IDX_W-1:0]    cfg_n_in,
    input  logic [OUT_W:0]      cfg_n_out,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic [IDX_W-1:0]    x_addr,
    output logic                mac_clr,
    output logic                mac_valid,
    output logic                mac_bias,
    input  logic                mac_ready,
    output logic                res_valid,
    output logic [OUT_W-1:0]    res_idx
`ifdef FC_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0]    N_IN_CAP  = IDX_W'(N_IN_MAX);
    localparam logic [OUT_W:0]      N_OUT_CAP = (OUT_W + 1)'(N_OUT_MAX);
    localparam logic [W_ADDR_W-1:0] STRIDE    = W_ADDR_W'(fc_w_stride(N_IN_MAX));
    localparam logic [W_ADDR_W-1:0] BIAS_SLOT = W_ADDR_W'(N_IN_MAX);
    localparam logic [DRN_W-1:0]    DRN_LAST  = DRN_W'(RD_LAT - 1);

    fc_seq_state_t      state_q, state_d;
    logic [IDX_W-1:0]   n_in_q, n_in_d;
    logic [OUT_W:0]     n_out_q, n_out_d;
    logic [OUT_W-1:0]   j_q, j_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               is_bias;

    assign is_bias = (k_q == n_in_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_in_q  <= '0;
            n_out_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            n_in_q  <= n_in_d;
            n_out_q <= n_out_d;
            j_q     <= j_d;
            k_q     <= k_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_in_d    = n_in_q;
        n_out_d   = n_out_q;
        j_d       = j_q;
        k_d       = k_q;
        drn_d     = drn_q;
        rd_en     = 1'b0;
        mac_clr   = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_in_d  = (cfg_n_in > N_IN_CAP) ? N_IN_CAP : cfg_n_in;
                    n_out_d = (cfg_n_out > N_OUT_CAP) ? N_OUT_CAP : cfg_n_out;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = (cfg_n_out == '0) ? DONE : CLR;
                end
            end
            CLR: begin
                mac_clr = 1'b1;
                k_d     = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (mac_ready) begin
                    rd_en = 1'b1;
                    if (is_bias) begin
                        drn_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Hold until the bias term has come out of the read pipe.
                if (drn_q == DRN_LAST) state_d = WRITE;
                else                   drn_d   = drn_q + DRN_W'(1);
            end
            WRITE: begin
                res_valid = 1'b1;
                if ({1'b0, j_q} == n_out_q - (OUT_W + 1)'(1)) begin
                    state_d = DONE;
                end else begin
                    j_d     = j_q + OUT_W'(1);
                    state_d = CLR;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort suppresses this cycle's strobes so nothing half-finished escapes.
        if (abort) begin
            state_d   = IDLE;
            rd_en     = 1'b0;
            mac_clr   = 1'b0;
            res_valid = 1'b0;
            done      = 1'b0;
        end
    end

    assign busy    = (state_q != IDLE);
    assign w_addr  = (state_q == ISSUE)
                   ? (W_ADDR_W'(j_q) * STRIDE + (is_bias ? BIAS_SLOT : W_ADDR_W'(k_q)))
                   : '0;
    assign x_addr  = (state_q == ISSUE) ? k_q : '0;
    assign res_idx = res_valid ? j_q : '0;

    fc_seq_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_vld_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort),
        .vld_i   (rd_en),
        .bias_i  (rd_en & is_bias),
        .vld_o   (mac_valid),
        .bias_o  (mac_bias)
    );

`ifdef FC_SEQ_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && start && !abort) begin
            stall_cnt_q <= '0;
        end else if (state_q == ISSUE && !mac_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer (RD_LAT=2, 10 inputs, 2 neurons).
// Expected reads/results are queued from a layer model at start and popped as the DUT emits them.
module tb_fc_layer_sequencer;

    localparam int RD_LAT = 2;
    localparam int NIM    = 10;
    localparam int NOM    = 2;
    localparam int IDX_W  = 4;
    localparam int OUT_W  = 1;
    localparam int WA_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             mac_ready = 1'b1;
    logic [IDX_W-1:0] cfg_n_in = '0;
    logic [OUT_W:0]   cfg_n_out = '0;
    logic             busy, done, rd_en, mac_clr, mac_valid, mac_bias, res_valid;
    logic [WA_W-1:0]  w_addr;
    logic [IDX_W-1:0] x_addr;
    logic [OUT_W-1:0] res_idx;
`ifdef FC_SEQ_PERF_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int vectors = 0;
    int errs    = 0;
    int q_w[$], q_x[$], q_b[$], q_mv_t[$], q_mv_b[$], q_res_idx[$], q_res_t[$];

    always #5 clk = ~clk;

    fc_layer_sequencer #(
        .N_IN_MAX  (NIM),
        .N_OUT_MAX (NOM),
        .RD_LAT    (RD_LAT),
        .IDX_W     (IDX_W),
        .OUT_W     (OUT_W),
        .W_ADDR_W  (WA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_n_in  (cfg_n_in),
        .cfg_n_out (cfg_n_out),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .w_addr    (w_addr),
        .x_addr    (x_addr),
        .mac_clr   (mac_clr),
        .mac_valid (mac_valid),
        .mac_bias  (mac_bias),
        .mac_ready (mac_ready),
        .res_valid (res_valid),
        .res_idx   (res_idx)
`ifdef FC_SEQ_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_low(input string tag);
        chk(tag, {busy, done, rd_en, w_addr, x_addr, mac_clr, mac_valid, mac_bias,
                  res_valid, res_idx}, 32'd0);
    endtask

    task automatic clear_q();
        q_w.delete(); q_x.delete(); q_b.delete(); q_mv_t.delete(); q_mv_b.delete();
        q_res_idx.delete(); q_res_t.delete();
    endtask

    // Runs one layer; stall_k = issue count after which mac_ready drops for stall_len
    // cycles (-1 none); poke_c = cycle at which a stray start is pulsed (-1 none).
    task automatic run_layer(input int n_in, input int n_out, input int stall_k,
                             input int stall_len, input int poke_c);
        int en_in, en_out, per, stall, exp_done, c, rd_cnt, clr_cnt, stall_left;
        int tw, tx, tb;
        bit trig, got_done;
        logic rdy_nxt;
        en_in  = (n_in > NIM) ? NIM : n_in;
        en_out = (n_out > NOM) ? NOM : n_out;
        per    = en_in + RD_LAT + 3;
        stall  = (stall_k >= 0 && en_out > 0 && stall_k <= en_in) ? stall_len : 0;
        exp_done = en_out * per + 1 + stall;
        clear_q();
        for (int j = 0; j < en_out; j++) begin
            for (int k = 0; k <= en_in; k++) begin
                q_w.push_back(j * (NIM + 1) + ((k == en_in) ? NIM : k));
                q_x.push_back(k);
                q_b.push_back((k == en_in) ? 1 : 0);
            end
            q_res_idx.push_back(j);
            q_res_t.push_back((j + 1) * per + stall);
        end
        @(posedge clk); #1;
        cfg_n_in  = n_in[IDX_W-1:0];
        cfg_n_out = n_out[OUT_W:0];
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        cfg_n_in  = 4'd3;
        cfg_n_out = 2'd1;
        c = 0; rd_cnt = 0; clr_cnt = 0; stall_left = 0; trig = 0; got_done = 0;
        while (c < exp_done + 20 && !got_done) begin
            @(negedge clk);
            c++;
            chk("busy_run", busy, 1);
            if (!mac_ready) chk("rd_en_stalled", rd_en, 0);
            if (rd_en) begin
                rd_cnt++;
                if (q_w.size() == 0) chk("extra_rd_en", 1, 0);
                else begin
                    tw = q_w.pop_front(); tx = q_x.pop_front(); tb = q_b.pop_front();
                    chk("w_addr", w_addr, tw);
                    if (tb == 0) chk("x_addr", x_addr, tx);
                    q_mv_t.push_back(c + RD_LAT);
                    q_mv_b.push_back(tb);
                end
            end
            if (mac_valid) begin
                if (q_mv_t.size() == 0) chk("extra_mac_valid", 1, 0);
                else begin
                    chk("mac_valid_cycle", c, q_mv_t.pop_front());
                    chk("mac_bias", mac_bias, q_mv_b.pop_front());
                end
            end
            if (mac_clr) clr_cnt++;
            if (res_valid) begin
                if (q_res_idx.size() == 0) chk("extra_res_valid", 1, 0);
                else begin
                    chk("res_idx", res_idx, q_res_idx.pop_front());
                    chk("res_cycle", c, q_res_t.pop_front());
                end
            end
            if (done) begin
                chk("done_cycle", c, exp_done);
                got_done = 1;
            end
            if (!trig && stall_k >= 0 && rd_cnt == stall_k) begin
                trig = 1;
                stall_left = stall_len;
            end
            rdy_nxt = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(posedge clk); #1;
            mac_ready = rdy_nxt;
            start     = (c == poke_c);
        end
        start = 1'b0;
        if (!got_done) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("mac_clr_count", clr_cnt, en_out);
        chk("reads_left", q_w.size(), 0);
        chk("mac_valid_left", q_mv_t.size(), 0);
        chk("results_left", q_res_idx.size(), 0);
`ifdef FC_SEQ_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, stall);
`endif
        mac_ready = 1'b1;
    endtask

    task automatic wait_addr(input int a, input int budget, output bit found);
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (rd_en && w_addr == a[WA_W-1:0]) found = 1;
        end
    endtask

    initial begin
        bit found;
        // Reset state
        repeat (2) @(negedge clk);
        chk_all_low("reset_outputs");
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_low("idle_outputs");

        run_layer(10, 2, -1, 0, -1);   // full layer
        run_layer(0, 2, -1, 0, -1);    // bias only
        run_layer(4, 0, -1, 0, -1);    // empty layer
        run_layer(10, 2, 4, 3, -1);    // backpressure at k=4
        run_layer(15, 3, -1, 0, -1);   // clamped config
        run_layer(5, 2, -1, 0, 6);     // start while busy is ignored

        // start and abort together in IDLE
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("start_abort_idle", {busy, done, rd_en, mac_clr}, 0);
        end

        // abort at k=6 of neuron 0 flushes in-flight reads
        @(posedge clk); #1;
        cfg_n_in = 4'd10; cfg_n_out = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_addr(5, 30, found);
        chk("abort_reach_k5", found, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_rd_en", rd_en, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("after_abort", {busy, rd_en, mac_valid, res_valid, done}, 0);
        end

        // async reset mid-ISSUE, then clean restart
        @(posedge clk); #1;
        cfg_n_in = 4'd5; cfg_n_out = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_addr(2, 30, found);
        chk("reset_reach_k2", found, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all_low("async_reset_outputs");
        repeat (2) @(negedge clk);
        chk_all_low("reset_held_outputs");
        rst_n = 1'b1;
        run_layer(3, 1, -1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
